// File: rtl/mul_div_unit_pkg.sv
// +------------------------------------------------------------------+
// | mul_div_unit_pkg : shared RV32M encodings, widths and constants  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package mul_div_unit_pkg;

    localparam int XLEN          = 32;
    localparam int MD_REG_ADDR_W = 5;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/mul_div_unit_sign_fix.sv
// +------------------------------------------------------------------+
// | md_sign_fix : conditional two's-complement negate (magnitude /   |
// | sign restore).  rev 1.0                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? -value : value;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// +------------------------------------------------------------------+
// | mul_div_unit : iterative RV32M multiply/divide execute unit      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH      = XLEN,
    parameter int REG_ADDR_W = MD_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [WIDTH-1:0]      op_a,
    input  logic [WIDTH-1:0]      op_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  wb_en
);

    md_state_t            state;
    logic [4:0]           count;
    logic [2:0]           fn;
    logic                 neg_res;
    logic                 neg_rem;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;

    logic                 a_signed;
    logic                 b_signed;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     a_in_mag;
    logic [WIDTH-1:0]     b_in_mag;
    logic                 div_zero;
    logic                 div_ovf;
    logic [WIDTH-1:0]     fast_res;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_sub;
    logic                 div_ok;
    logic                 unused_div_msb;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     fix_res;

    assign a_signed = (funct3 == MD_MUL) || (funct3 == MD_MULH) || (funct3 == MD_MULHSU)
                   || (funct3 == MD_DIV) || (funct3 == MD_REM);
    assign b_signed = (funct3 == MD_MUL) || (funct3 == MD_MULH)
                   || (funct3 == MD_DIV) || (funct3 == MD_REM);
    assign sign_a   = a_signed & op_a[WIDTH-1];
    assign sign_b   = b_signed & op_b[WIDTH-1];

    md_sign_fix #(.W(WIDTH)) u_mag_a (.value(op_a), .negate(sign_a), .result(a_in_mag));
    md_sign_fix #(.W(WIDTH)) u_mag_b (.value(op_b), .negate(sign_b), .result(b_in_mag));

    // Cases with an architecturally fixed answer bypass the iterative datapath.
    assign div_zero = funct3[2] && (op_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
    assign fast_res = div_zero ? (funct3[1] ? op_a : DIV0_QUOT)
                               : (funct3[1] ? '0   : INT_MIN);

    // Shift-add: low half of acc holds the unconsumed multiplier bits.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);

    // Restoring division: shift next dividend bit into the partial remainder.
    assign div_shift      = {rem, quot[WIDTH-1]};
    assign div_ok         = (div_shift >= {1'b0, b_mag});
    assign div_sub        = div_shift - {1'b0, b_mag};
    assign unused_div_msb = div_sub[WIDTH];

    md_sign_fix #(.W(2*WIDTH)) u_fix_prod (.value(acc),  .negate(neg_res), .result(prod_fix));
    md_sign_fix #(.W(WIDTH))   u_fix_quot (.value(quot), .negate(neg_res), .result(quot_fix));
    md_sign_fix #(.W(WIDTH))   u_fix_rem  (.value(rem),  .negate(neg_rem), .result(rem_fix));

    assign fix_res = fn[2] ? (fn[1] ? rem_fix : quot_fix)
                           : ((fn == MD_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            count   <= '0;
            fn      <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            a_mag   <= '0;
            b_mag   <= '0;
            acc     <= '0;
            quot    <= '0;
            rem     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_en   <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            done  <= 1'b0;
            wb_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        fn      <= funct3;
                        rd_out  <= rd_in;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        a_mag   <= a_in_mag;
                        b_mag   <= b_in_mag;
                        acc     <= {{WIDTH{1'b0}}, b_in_mag};
                        quot    <= a_in_mag;
                        rem     <= '0;
                        count   <= '0;
                        if (div_zero || div_ovf) begin
                            result <= fast_res;
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            wb_en  <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (fn[2]) begin
                            quot <= {quot[WIDTH-2:0], div_ok};
                            rem  <= div_ok ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        result <= fix_res;
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        wb_en  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// +------------------------------------------------------------------+
// | tb_mul_div_unit : scoreboard bench for mul_div_unit              |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        wb_en;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .abort(abort),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        time         t_done;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passed = 0;
    logic [31:0] last_res = '0;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Reference model straight from the RV32M definitions.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sbv = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            MD_MUL:    begin p = 64'(sa * sbv); return p[31:0]; end
            MD_MULH:   begin p = 64'(sa * sbv); return p[63:32]; end
            MD_MULHSU: begin p = 64'(sa * ub);  return p[63:32]; end
            MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            MD_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sbv);
            end
            MD_DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            MD_REM:    begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sbv);
            end
            default:   begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || ((f == MD_DIV || f == MD_REM) &&
                        a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", busy, done, n);
        end
    endtask

    // Returns at the negedge of cycle 1 (first cycle after acceptance).
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input bit expect_done);
        time t0;
        int  lat;
        wait_idle();
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        t0  = $time;
        lat = is_fast(f, a, b) ? 1 : 34;
        if (expect_done) sb.push_back('{exp_res, rd, t0 + time'(lat * 10 - 5)});
        @(negedge clk);
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom);
        rd_in  = 5'($urandom);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done || wb_en) check("wb_en_eq_done", 64'(wb_en), 64'(done));
            if (done) begin
                check("done_not_back_to_back", 64'(prev_done), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: result %0h with nothing outstanding", result);
                end else begin
                    mon_e = sb.pop_front();
                    check("result",    64'(result), 64'(mon_e.res));
                    check("rd_out",    64'(rd_out), 64'(mon_e.rd));
                    check("done_time", 64'($time),  64'(mon_e.t_done));
                    last_res = mon_e.res;
                end
            end
        end
        prev_done = done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t dv[11];
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        dv = '{
            '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
            '{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
            '{MD_DIVU,   32'd100,       32'd7,         32'd14},
            '{MD_REMU,   32'd100,       32'd7,         32'd2},
            '{MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF},
            '{MD_REM,    32'd5,         32'd0,         32'd5},
            '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0}
        };

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'({busy, done, wb_en, rd_out, result}), 64'd0);
        reset = 1'b0;

        // MUL with cycle-accurate busy profile
        issue(MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 1'b1);
        check("busy_cycle1", 64'(busy), 64'd1);
        repeat (32) @(negedge clk);
        check("busy_done_cycle33", 64'({busy, done}), 64'b10);
        @(negedge clk);
        check("busy_cycle34", 64'(busy), 64'd0);

        foreach (dv[i]) issue(dv[i].f, dv[i].a, dv[i].b, 5'(i + 1), dv[i].r, 1'b1);

        // start during CALC must be ignored
        issue(MD_DIVU, 32'd1000, 32'd3, 5'd9, 32'd333, 1'b1);
        repeat (4) @(negedge clk);
        funct3 = MD_MUL; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // abort in CALC cycle 10
        issue(MD_MUL, 32'd123, 32'd456, 5'd4, 32'h0, 1'b0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result_kept", 64'(result), 64'(last_res));
        repeat (40) @(negedge clk);

        // abort together with start in IDLE
        funct3 = MD_MULHU; op_a = 32'd9; op_b = 32'd9; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle", 64'({busy, done}), 64'd0);

        // asynchronous reset mid-CALC
        issue(MD_REM, 32'd77, 32'd5, 5'd6, 32'h0, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", 64'({busy, done, wb_en, rd_out, result}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_res = '0;

        for (int n = 0; n < 60; n++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            issue(rf, ra, rb, 5'($urandom_range(0, 31)), model(rf, ra, rb), 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M execute-stage unit. Consumes the two register-file read operands (rs1, rs2) and produces a 32-bit result plus a write-back request (rd, enable) for the register file write port.
- Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Uses a start/busy/done handshake so the multi-cycle control FSM stalls until the result is ready.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  WIDTH  rs1 value (register file data_out1)
- op_b  input  WIDTH  rs2 value (register file data_out2)
- rd_in  input  REG_ADDR_W  destination register index
- abort  input  1  flush: cancels any in-flight op
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  final value, held until next accepted start
- rd_out  output  REG_ADDR_W  latched rd_in
- wb_en  output  1  equals done; drives register file write_enable

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset (async, any state):
  - state=IDLE; busy, done, wb_en = 0; result, rd_out = 0; counter and datapath registers = 0.
  - Reset mid-operation discards the op; no done pulse follows.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch funct3, op_a, op_b and rd_in. Inputs are don't-care afterwards.
  - Normal ops go to CALC with counter=0.
  - Fast path goes straight to DONE (done on the next cycle, latency 1):
    - Divide by zero (op_b=0, funct3[2]=1): DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = op_a.
    - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- CALC: exactly 32 cycles, one bit per cycle; counter 0..31, then go to FIX.
  - Multiply: shift-add on operand magnitudes into a 64-bit accumulator.
  - Divide: restoring division on magnitudes; 32-bit quotient and 33-bit partial remainder.
- Magnitude and sign rules:
  - op_a is treated as signed for MUL, MULH, MULHSU, DIV, REM.
  - op_b is treated as signed for MUL, MULH, DIV, REM.
  - MUL's low 32 bits are sign-agnostic, so either treatment is acceptable for MUL.
- FIX (1 cycle): apply sign correction, select the output word and register it into result.
  - Product is negated if operand signs differ. MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
  - Quotient is negated if signs differ (signed ops). Remainder takes the sign of the dividend.
- DONE (1 cycle): done=1, wb_en=1, rd_out valid; then return to IDLE.
- Latency: start accepted at edge 0 -> CALC cycles 1..32 -> FIX cycle 33 -> done high in cycle 34.
- start while busy or in DONE: ignored, no queueing.
- abort:
  - In CALC or FIX: return to IDLE next edge; no done pulse; result keeps its previous value.
  - In IDLE or DONE: no effect, so an in-progress done pulse still completes.
  - abort and start together in IDLE: abort wins; nothing is accepted.
- rd_out=0 still pulses wb_en; the register file ignores writes to x0.
- done is never asserted for two consecutive cycles.

Decomposition:
- Shared package (processor-wide):
  - funct3 encodings MD_MUL..MD_REMU
  - FSM state encoding
  - WIDTH/XLEN constant and REG_ADDR_W
  - Value constants DIV0_QUOT = 0xFFFFFFFF and INT_MIN = 0x80000000
- One natural sub-module: md_sign_fix, a combinational magnitude/negate helper used at operand entry and in FIX. Everything else stays in mul_div_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done in cycle 34 after start; busy high cycles 1..33; wb_en=done; rd_out=rd_in.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast path (done in cycle 1):
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Handshake:
  - start pulsed again during CALC with different operands -> ignored; the first op's result is produced at cycle 34.
  - Operands changed after acceptance -> result unaffected.
- Cancellation:
  - abort at cycle 10 of CALC -> busy=0 next cycle, no done pulse, result unchanged.
  - reset asserted mid-CALC (asynchronously, off clock edge) -> all outputs 0 immediately.
  - After either, a new start completes normally.
